// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM state encoding and frame constants.
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
package imem_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LEN_W      = 16;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  function automatic logic len_too_big(
    input logic [LEN_W-1:0] len,
    input int unsigned      addr_w
  );
    return 32'(len) > (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian 4-byte packer; emits a registered word with a one-cycle
// word_valid pulse on the edge after its fourth byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  data,
  output logic        last,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  idx;
  logic [23:0] sr;

  assign last = take && (idx == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      sr         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        idx <= '0;
        sr  <= '0;
      end else if (take) begin
        idx <= idx + 2'd1;
        sr  <= {sr[15:0], data};
        if (last) begin
          word       <= {sr, data};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-framed byte image into instruction memory, holding the
// core in reset until complete. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CSUM;
`else
  localparam state_t FIN = DONE;
`endif

  state_t            state;
  logic [7:0]        hi;
  logic [LEN_W-1:0]  rem;
  logic [ADDR_W-1:0] addr;
  logic              take;
  logic              rearm;
  logic              last;
  logic [LEN_W-1:0]  len_full;

  assign in_ready = (state == LEN_HI) || (state == LEN_LO)
                 || (state == DATA)   || (state == CSUM);
  assign take     = in_valid && in_ready;
  assign rearm    = start && ((state == DONE) || (state == ERR));
  assign len_full = {hi, in_data};

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (rearm),
    .take       (take && (state == DATA)),
    .data       (in_data),
    .last       (last),
    .word       (imem_wdata),
    .word_valid (imem_we)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (reset || rearm) csum <= '0;
    else if (take)      csum <= csum ^ in_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LEN_HI;
      hi         <= '0;
      rem        <= '0;
      addr       <= '0;
      imem_waddr <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_reset  <= 1'b1;
    end else begin
      if (rearm) begin
        done      <= 1'b0;
        error     <= 1'b0;
        cpu_reset <= 1'b1;
      end else begin
        done      <= (state == DONE);
        error     <= (state == ERR);
        cpu_reset <= (state != DONE);
      end
      unique case (state)
        LEN_HI: if (take) begin
          hi    <= in_data;
          state <= LEN_LO;
        end
        LEN_LO: if (take) begin
          rem <= len_full;
          if (len_full == '0)
            state <= FIN;
          else if (len_too_big(len_full, ADDR_W))
            state <= ERR;
          else
            state <= DATA;
        end
        DATA: if (last) begin
          imem_waddr <= addr;
          addr       <= addr + 1'b1;
          rem        <= rem - 1'b1;
          if (rem == LEN_W'(1)) state <= FIN;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: if (take) state <= (in_data == csum) ? DONE : ERR;
`else
        CSUM: state <= ERR;
`endif
        DONE, ERR: if (start) begin
          state <= LEN_HI;
          addr  <= '0;
        end
        default: state <= LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=2 so overflow/boundary are cheap).
// Honours IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, imem_we, cpu_reset, done, error;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;

  int n_chk  = 0;
  int n_fail = 0;
  int drops  = 0;
  bit watch  = 1'b0;
  int wa[$];
  logic [31:0] wd[$];
  logic [7:0]  fr[$];

  imem_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(int'(imem_waddr));
      wd.push_back(imem_wdata);
    end
    if (watch && !in_ready) drops++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    @(negedge clk);
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // fr holds the whole frame; watch covers data bytes only
  task automatic send_frame(input bit gap, input bit mon,
                            input bit with_cs, input logic [7:0] cs);
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i], gap);
      if (i == 1 && fr.size() > 2) watch = mon;
      if (i == fr.size() - 1) watch = 1'b0;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (with_cs) send_byte(cs, gap);
`else
    if (with_cs && cs === 8'hxx) send_byte(cs, gap);
`endif
  endtask

  task automatic wait_end(input string tag);
    int t = 0;
    while (!done && !error && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_end_timeout"}, 32'(done | error), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic check_t1(input string tag);
    check({tag, "_nwr"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check({tag, "_a0"}, 32'(wa[0]), 32'd0);
      check({tag, "_d0"}, wd[0], 32'h20080005);
      check({tag, "_a1"}, 32'(wa[1]), 32'd1);
      check({tag, "_d1"}, wd[1], 32'hAC080000);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("rst");
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_waddr", 32'(imem_waddr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);

    // 1: back-to-back two-word image
    clear_log();
    fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
           8'hAC, 8'h08, 8'h00, 8'h00};
    send_frame(1'b0, 1'b0, 1'b1, 8'h8B);
    wait_end("t1");
    @(negedge clk);
    check_t1("t1");
    check("t1_ready", 32'(in_ready), 32'd0);
    pulse_start();
    check_idle("t1_start");

    // 2: same image, valid toggling
    clear_log();
    drops = 0;
    send_frame(1'b1, 1'b1, 1'b1, 8'h8B);
    wait_end("t2");
    @(negedge clk);
    check_t1("t2");
    check("t2_ready_drops", 32'(drops), 32'd0);
    pulse_start();

    // 3: len=5 exceeds 4-word memory
    clear_log();
    fr = '{8'h00, 8'h05};
    send_frame(1'b0, 1'b0, 1'b0, 8'h00);
    wait_end("t3");
    repeat (3) @(negedge clk);
    check("t3_error", 32'(error), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t3_nwr", 32'(wa.size()), 32'd0);
    check("t3_ready", 32'(in_ready), 32'd0);
    pulse_start();
    check_idle("t3_start");

    // 4: reset mid-load, then fresh len=1 image
    clear_log();
    fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08};
    send_frame(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t4_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check("t4_a0", 32'(wa[0]), 32'd0);
      check("t4_d0", wd[0], 32'h20080005);
    end
    check_idle("t4_rst");
    check("t4_we", 32'(imem_we), 32'd0);
    check("t4_waddr", 32'(imem_waddr), 32'd0);
    check("t4_wdata", imem_wdata, 32'd0);
    clear_log();
    fr = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(1'b0, 1'b0, 1'b1, 8'h45);
    wait_end("t4b");
    @(negedge clk);
    check("t4b_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check("t4b_a0", 32'(wa[0]), 32'd0);
      check("t4b_d0", wd[0], 32'h11223344);
    end
    check("t4b_done", 32'(done), 32'd1);
    pulse_start();

    // 5: empty image
    clear_log();
    fr = '{8'h00, 8'h00};
    send_frame(1'b0, 1'b0, 1'b1, 8'h00);
    wait_end("t5");
    repeat (2) @(negedge clk);
    check("t5_done", 32'(done), 32'd1);
    check("t5_cpu_reset", 32'(cpu_reset), 32'd0);
    check("t5_nwr", 32'(wa.size()), 32'd0);
    pulse_start();

    // 6: len equals capacity, address wraps without extra write
    clear_log();
    fr = '{8'h00, 8'h04};
    for (int i = 1; i <= 16; i++) fr.push_back(8'(i));
    send_frame(1'b0, 1'b0, 1'b1, 8'h14);
    wait_end("t6");
    repeat (4) @(negedge clk);
    check("t6_nwr", 32'(wa.size()), 32'd4);
    if (wa.size() == 4) begin
      check("t6_a3", 32'(wa[3]), 32'd3);
      check("t6_d0", wd[0], 32'h01020304);
      check("t6_d3", wd[3], 32'h0D0E0F10);
    end
    check("t6_done", 32'(done), 32'd1);
    check("t6_error", 32'(error), 32'd0);
    pulse_start();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 7: wrong checksum rejected, right one accepted
    clear_log();
    fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
           8'hAC, 8'h08, 8'h00, 8'h00};
    send_frame(1'b0, 1'b0, 1'b1, 8'h01);
    wait_end("t7");
    @(negedge clk);
    check("t7_error", 32'(error), 32'd1);
    check("t7_cpu_reset", 32'(cpu_reset), 32'd1);
    pulse_start();
    clear_log();
    send_frame(1'b0, 1'b0, 1'b1, 8'h8B);
    wait_end("t7b");
    @(negedge clk);
    check_t1("t7b");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
